// File: rtl/as2650_uart_pkg.sv
// rtl/as2650_uart_pkg.sv - shared constants, state type and divider clamp for the as2650 UART
package as2650_uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV_LO = 2'd2;
    localparam logic [1:0] ADDR_DIV_HI = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/as2650_uart_fifo.sv
// rtl/as2650_uart_fifo.sv - synchronous FIFO, extra pointer bit separates full from empty
module as2650_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/as2650_uart.sv
// rtl/as2650_uart.sv - 8N1 UART on the as2650 I/O bus: TX FIFO, RX holding register, level irq
module as2650_uart
    import as2650_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RST    = 16'd103
) (
    input  logic       wb_clk_i,
    input  logic       rst_n,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    input  logic       bus_we,
    input  logic       bus_re,
    output logic [7:0] bus_rdata,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       tx_oeb,
    output logic       irq
);

    logic [15:0] div_q;
    logic [15:0] eff_div;
    logic        rd_en, data_rd, stat_rd, fifo_push;
    logic        fifo_full, fifo_empty, tx_pop;
    logic [7:0]  fifo_dout;

    assign eff_div   = clamp_div(div_q);
    assign rd_en     = bus_re && !bus_we;
    assign data_rd   = rd_en && (bus_addr == ADDR_DATA);
    assign stat_rd   = rd_en && (bus_addr == ADDR_STATUS);
    assign fifo_push = bus_we && (bus_addr == ADDR_DATA);
    assign tx_oeb    = 1'b0;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_RST;
        end else if (bus_we) begin
            if (bus_addr == ADDR_DIV_LO) div_q[7:0]  <= bus_wdata;
            if (bus_addr == ADDR_DIV_HI) div_q[15:8] <= bus_wdata;
        end
    end

    as2650_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (bus_wdata),
        .pop   (tx_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Each bit runs from cnt 0 to lim; lim is relatched at every bit boundary.
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_lim, tx_lim_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_tick, tx_line, tx_empty;

    assign tx_tick  = (tx_cnt == tx_lim);
    assign tx_empty = fifo_empty && (tx_state == IDLE);
    assign tx_line  = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_lim_n   = tx_lim;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = START;
                    tx_shift_n = fifo_dout;
                    tx_lim_n   = eff_div;
                end
            end
            START: if (tx_tick) begin
                tx_state_n = DATA;
                tx_cnt_n   = '0;
                tx_lim_n   = eff_div;
                tx_bit_n   = '0;
            end
            DATA: if (tx_tick) begin
                tx_cnt_n   = '0;
                tx_lim_n   = eff_div;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                if (tx_bit == 3'd7) tx_state_n = STOP;
                else                tx_bit_n   = tx_bit + 3'd1;
            end
            STOP: if (tx_tick) begin
                tx_cnt_n = '0;
                tx_lim_n = eff_div;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = START;
                    tx_shift_n = fifo_dout;
                end else begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_lim   <= DIV_MIN;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_lim   <= tx_lim_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_o     <= tx_line;
        end
    end

    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_lim, rx_lim_n;
    logic [16:0] rx_half;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n, rx_data;
    logic        rx_s1, rx_s2, rx_prev, rx_tick;
    logic        rx_load, rx_load_n, rx_ferr, rx_ferr_n;
    logic        rx_valid, rx_overrun, frame_err;

    assign rx_tick = (rx_cnt == rx_lim);
    assign rx_half = ({1'b0, rx_lim} + 17'd1) >> 1;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_lim_n   = rx_lim;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load_n  = 1'b0;
        rx_ferr_n  = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) begin
                    rx_state_n = START;
                    rx_lim_n   = eff_div;
                end
            end
            START: if ({1'b0, rx_cnt} == rx_half) begin
                rx_cnt_n   = '0;
                rx_lim_n   = eff_div;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: if (rx_tick) begin
                rx_cnt_n   = '0;
                rx_lim_n   = eff_div;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'd7) rx_state_n = STOP;
                else                rx_bit_n   = rx_bit + 3'd1;
            end
            STOP: if (rx_tick) begin
                rx_state_n = IDLE;
                rx_load_n  = rx_s2;
                rx_ferr_n  = !rx_s2;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_lim   <= DIV_MIN;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_load  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx_i;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_lim   <= rx_lim_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_load  <= rx_load_n;
            rx_ferr  <= rx_ferr_n;
        end
    end

    // A DATA read coinciding with a load returns the old byte, then the new one lands without overrun.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_load && (!rx_valid || data_rd)) rx_data <= rx_shift;
            rx_valid   <= rx_load || (rx_valid && !data_rd);
            rx_overrun <= (rx_load && rx_valid && !data_rd) || (rx_overrun && !stat_rd);
            frame_err  <= rx_ferr || (frame_err && !stat_rd);
        end
    end

    assign irq = rx_valid;

    logic [7:0] status_byte;
    always_comb begin
        status_byte                = '0;
        status_byte[ST_TX_FULL]    = fifo_full;
        status_byte[ST_TX_EMPTY]   = tx_empty;
        status_byte[ST_RX_VALID]   = rx_valid;
        status_byte[ST_RX_OVERRUN] = rx_overrun;
        status_byte[ST_FRAME_ERR]  = frame_err;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata <= '0;
        end else if (rd_en) begin
            case (bus_addr)
                ADDR_DATA:   bus_rdata <= rx_data;
                ADDR_STATUS: bus_rdata <= status_byte;
                ADDR_DIV_LO: bus_rdata <= div_q[7:0];
                ADDR_DIV_HI: bus_rdata <= div_q[15:8];
                default:     bus_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_as2650_uart.sv
// tb/tb_as2650_uart.sv - directed/randomized bench for as2650_uart with a frame-level reference model
module tb_as2650_uart;

    logic       wb_clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic [7:0] bus_wdata = 8'd0;
    logic       bus_we = 1'b0;
    logic       bus_re = 1'b0;
    logic [7:0] bus_rdata;
    logic       rx_i = 1'b1;
    logic       tx_o;
    logic       tx_oeb;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;

    // Receive-side model: what software should see, derived from whole frames.
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] m_byte = 8'd0;

    as2650_uart #(.FIFO_DEPTH(4), .DIV_RST(16'd103)) dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .rx_i      (rx_i),
        .tx_o      (tx_o),
        .tx_oeb    (tx_oeb),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(posedge wb_clk_i);
        #1 bus_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_re   = 1'b1;
        @(posedge wb_clk_i);
        #1 bus_re = 1'b0;
        d = bus_rdata;
    endtask

    function automatic logic [7:0] m_status();
        return {3'b000, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
    endfunction

    task automatic status_chk(input string tag);
        logic [7:0] d;
        rd(2'd1, d);
        chk(tag, d, m_status());
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic data_chk(input string tag);
        logic [7:0] d;
        rd(2'd0, d);
        chk(tag, d, m_byte);
        m_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int p);
        for (int i = 0; i < 10; i++) begin
            rx_i = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            repeat (p) @(posedge wb_clk_i);
            #1;
        end
        rx_i = 1'b1;
        repeat (4) @(posedge wb_clk_i);
        #1;
        if (!stop)        m_ferr = 1'b1;
        else if (m_valid) m_ovr  = 1'b1;
        else begin
            m_byte  = b;
            m_valid = 1'b1;
        end
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (tx_o !== 1'b0 && n < budget);
        chk("tx_start_seen", tx_o, 1'b0);
    endtask

    // Bits before nsw last p0 clocks, the rest p1; pre means the first sample is already current.
    task automatic check_frame(input logic [7:0] b, input int p0, input int p1, input int nsw, input logic pre);
        for (int i = 0; i < 10; i++) begin
            int p = (i < nsw) ? p0 : p1;
            int ones = 0;
            logic eb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int c = 0; c < p; c++) begin
                if (!(pre && i == 0 && c == 0)) @(negedge wb_clk_i);
                ones += int'(tx_o);
            end
            chk($sformatf("tx_bit%0d_of_%02h", i, b), ones, eb ? p : 0);
        end
    endtask

    initial begin
        logic [7:0] d, b, b1, b2;
        int ones;

        repeat (2) @(negedge wb_clk_i);
        chk("rst_tx_o", tx_o, 1'b1);
        chk("rst_tx_oeb", tx_oeb, 1'b0);
        chk("rst_rdata", bus_rdata, 8'h00);
        chk("rst_irq", irq, 1'b0);
        @(posedge wb_clk_i);
        #1 rst_n = 1'b1;
        status_chk("rst_status");
        rd(2'd2, d); chk("rst_div_lo", d, 8'h67);
        rd(2'd3, d); chk("rst_div_hi", d, 8'h00);

        // TX single frames at DIV=3
        wr(2'd2, 8'd3);
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'h55 : 8'($urandom);
            wr(2'd0, b);
            @(negedge wb_clk_i); chk("tx_lat_n1", tx_o, 1'b1);
            @(negedge wb_clk_i); chk("tx_lat_n2", tx_o, 1'b1);
            check_frame(b, 4, 4, 10, 1'b0);
            @(negedge wb_clk_i); chk("tx_idle_after", tx_o, 1'b1);
            @(posedge wb_clk_i); #1;
            status_chk("tx_empty_after");
        end

        // TX FIFO fill, drop at full, back-to-back frames
        fork
            begin
                for (int i = 0; i < 5; i++) wr(2'd0, 8'hA1 + 8'(i));
                rd(2'd1, d);
                chk("tx_full_status", d, 8'h01);
                wr(2'd0, 8'hA6);
            end
            begin
                wait_fall(10);
                for (int i = 0; i < 5; i++) check_frame(8'hA1 + 8'(i), 4, 4, 10, i == 0);
            end
        join
        ones = 0;
        repeat (12) begin
            @(negedge wb_clk_i);
            ones += int'(tx_o);
        end
        chk("tx_drop_idle", ones, 12);
        @(posedge wb_clk_i); #1;
        status_chk("tx_fifo_drained");

        // RX at DIV=7
        wr(2'd2, 8'd7);
        send_rx(8'hC3, 1'b1, 8);
        chk("rx_irq_set", irq, m_valid);
        data_chk("rx_data_c3");
        chk("rx_irq_clr", irq, 1'b0);
        send_rx(8'($urandom), 1'b0, 8);
        status_chk("rx_frame_err");
        status_chk("rx_ferr_cleared");
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_rx(b1, 1'b1, 8);
        send_rx(b2, 1'b1, 8);
        status_chk("rx_overrun");
        status_chk("rx_ovr_cleared");
        data_chk("rx_first_kept");
        status_chk("rx_all_clear");

        // False start, then a real frame
        rx_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1 rx_i = 1'b1;
        repeat (20) @(posedge wb_clk_i);
        #1;
        status_chk("rx_false_start");
        send_rx(8'($urandom), 1'b1, 8);
        data_chk("rx_after_false_start");

        for (int i = 0; i < 8; i++) begin
            send_rx(8'($urandom), ($urandom % 5) != 0, 8);
            chk("rx_rand_irq", irq, m_valid);
            case ($urandom % 3)
                0: data_chk("rx_rand_data");
                1: status_chk("rx_rand_status");
                default: ;
            endcase
        end
        status_chk("rx_rand_final_status");
        data_chk("rx_rand_final_data");
        status_chk("rx_rand_end");

        // Reset in the middle of a TX frame
        wr(2'd2, 8'd3);
        b = 8'($urandom) & 8'hFB;
        wr(2'd0, b);
        wr(2'd0, 8'($urandom));
        repeat (15) @(posedge wb_clk_i);
        #1 chk("tx_pre_rst_low", tx_o, 1'b0);
        rst_n = 1'b0;
        #1 chk("rst_async_tx_o", tx_o, 1'b1);
        chk("rst_mid_rdata", bus_rdata, 8'h00);
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h00;
        @(posedge wb_clk_i);
        #1 rst_n = 1'b1;
        ones = 0;
        repeat (30) begin
            @(negedge wb_clk_i);
            ones += int'(tx_o);
        end
        chk("rst_fifo_flushed", ones, 30);
        @(posedge wb_clk_i); #1;
        status_chk("rst_mid_status");
        rd(2'd2, d); chk("rst_mid_div_lo", d, 8'h67);

        // DIV=0 clamps to a 3-clock bit
        wr(2'd2, 8'd0);
        rd(2'd2, d); chk("div_lo_raw", d, 8'h00);
        b = 8'($urandom);
        wr(2'd0, b);
        @(negedge wb_clk_i); chk("clamp_lat_n1", tx_o, 1'b1);
        @(negedge wb_clk_i); chk("clamp_lat_n2", tx_o, 1'b1);
        check_frame(b, 3, 3, 10, 1'b0);
        @(posedge wb_clk_i); #1;

        // DIV change during data bit 2: bits 0-3 at 6 clocks, 4-9 at 10
        wr(2'd2, 8'd5);
        b = 8'($urandom);
        wr(2'd0, b);
        fork
            begin
                repeat (21) @(posedge wb_clk_i);
                #1 wr(2'd2, 8'd9);
            end
            begin
                @(negedge wb_clk_i); chk("chg_lat_n1", tx_o, 1'b1);
                @(negedge wb_clk_i); chk("chg_lat_n2", tx_o, 1'b1);
                check_frame(b, 6, 10, 4, 1'b0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
